spi_master: RTL

- Synthesizable SPI bus master for the SoC peripheral bus; drives serial clock, chip selects and master-out data, and samples slave-in data.
- Bit-compatible with the team's SPI slave bench model: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, and multi-byte frames while ncs is held low.
- Sits behind the SPI register block, which supplies byte, chip-select index, divider and hold flag, and reads back rx_data on done.

---
 rtl/spi_master.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 bus master, MSB first, 8-bit frames, chip select optionally held across bytes.
// Latency: done pulses 16*(divider+1) clk cycles after the start-accept edge; all outputs registered.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input (sample own mosi, keep all selects high).
module spi_master #(
  parameter int NUM_CS    = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           tx_data,
  input  logic [2:0]           cs_sel,
  input  logic                 cs_hold,
  input  logic                 cs_release,
  input  logic [DIV_WIDTH-1:0] divider,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rx_data,
  output logic                 spi_clk,
  output logic [NUM_CS-1:0]    spi_ncs,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [2:0]           bit_cnt;
  logic [7:0]           tx_sh;
  logic [7:0]           rx_sh;
  logic                 hold_q;
  logic                 sample_bit;
  logic                 no_select;
  logic                 phase_end;

  // Active-low one-hot select mask; an out-of-range index selects nothing.
  function automatic logic [NUM_CS-1:0] sel_mask(input logic [2:0] idx);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (i == int'(idx)) m[i] = 1'b0;
    end
    return m;
  endfunction

  // Choose the sampled data source and whether a slave gets selected at all.
  always_comb begin
`ifdef SPI_MASTER_LOOPBACK_EN
    sample_bit = loopback ? spi_mosi : spi_miso;
    no_select  = loopback;
`else
    sample_bit = spi_miso;
    no_select  = 1'b0;
`endif
    phase_end = (cnt == div_q);
  end

  // Transfer FSM: each SETUP/HIGH/LOW phase lasts divider+1 cycles; the edge that ends
  // the 8th high phase drops spi_clk and completes the byte, so a back-to-back start
  // in the done cycle gets its own full setup phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= '0;
      bit_cnt  <= 3'd0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      hold_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= 8'h00;
      spi_clk  <= 1'b0;
      spi_ncs  <= '1;
      spi_mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh    <= tx_data;
            hold_q   <= cs_hold;
            div_q    <= divider;
            cnt      <= '0;
            bit_cnt  <= 3'd0;
            busy     <= 1'b1;
            spi_ncs  <= no_select ? '1 : sel_mask(cs_sel);
            spi_mosi <= tx_data[7];
            state    <= SETUP;
          end else if (cs_release) begin
            spi_ncs <= '1;
          end
        end
        SETUP, LOW: begin
          if (phase_end) begin
            cnt     <= '0;
            spi_clk <= 1'b1;
            rx_sh   <= {rx_sh[6:0], sample_bit};
            state   <= HIGH;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (phase_end) begin
            cnt     <= '0;
            spi_clk <= 1'b0;
            if (bit_cnt == 3'd7) begin
              rx_data <= rx_sh;
              done    <= 1'b1;
              busy    <= 1'b0;
              if (!hold_q) spi_ncs <= '1;
              state   <= IDLE;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              spi_mosi <= tx_sh[6];
              tx_sh    <= {tx_sh[6:0], 1'b0};
              state    <= LOW;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
